add_sub_pipe: RTL

//   Parametrised two's-complement adder/subtractor, carry chain cut into CHUNK-bit pipeline stages.
//   Per-op mode select, valid/ready handshake both sides, registered carry/overflow/zero/negative flags.

---
 rtl/add_sub_pipe_pkg.sv | 19 +
 rtl/add_sub_pipe_if.sv | 27 ++
 rtl/add_sub_chunk.sv | 21 ++
 rtl/add_sub_pipe.sv | 139 +++++++++++++
 4 files changed

// File: rtl/add_sub_pipe_pkg.sv
// Shared types and default sizing for the pipelined adder/subtractor.
package add_sub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic neg;
    } flags_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

endpackage

// File: rtl/add_sub_pipe_if.sv
// Operand/result handshake bundle for add_sub_pipe; WIDTH must match the attached pipe.
interface add_sub_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, z, cout, ovf, zero, neg
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, z, cout, ovf, zero, neg
    );
endinterface

// File: rtl/add_sub_chunk.sv
// CHUNK-bit ripple slice: sum, carry out, and the carry that entered its top bit.
module add_sub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);
    logic [CHUNK:0] full_sum;

    always_comb begin
        full_sum = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        s        = full_sum[CHUNK-1:0];
        cout     = full_sum[CHUNK];
        // top sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly
        cmsb     = full_sum[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
    end
endmodule

// File: rtl/add_sub_pipe.sv
// Two's-complement add/sub with the carry chain cut into CHUNK-bit pipeline stages,
// valid/ready on both sides and registered carry/overflow/zero/negative flags.
module add_sub_pipe
    import add_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input logic           clk,
    input logic           rst,
    add_sub_pipe_if.slave bus
);
    localparam int SAFE_CHUNK = (CHUNK > 0) ? CHUNK : 1;
    localparam int STAGES     = WIDTH / SAFE_CHUNK;
    localparam int LAST       = STAGES - 1;

    if ((CHUNK < 1) || ((WIDTH % SAFE_CHUNK) != 0) || (WIDTH < CHUNK)) begin : g_param_check
        $error("add_sub_pipe: WIDTH must be a non-zero multiple of CHUNK, CHUNK >= 1");
    end

    logic en;
    logic accept;
    logic sub_op;

    // Per-stage operands feeding each slice: upper chunks of a/bb ride along, lower sum bits accumulate.
    logic [WIDTH-1:0] a_src  [STAGES];
    logic [WIDTH-1:0] bb_src [STAGES];
    logic [WIDTH-1:0] s_src  [STAGES];
    logic             cin_src[STAGES];

    logic [CHUNK-1:0] chunk_s[STAGES];
    logic             chunk_c[STAGES];
    logic             chunk_m[STAGES];

    logic [WIDTH-1:0] a_d    [STAGES];
    logic [WIDTH-1:0] a_q    [STAGES];
    logic [WIDTH-1:0] bb_d   [STAGES];
    logic [WIDTH-1:0] bb_q   [STAGES];
    logic [WIDTH-1:0] s_d    [STAGES];
    logic [WIDTH-1:0] s_q    [STAGES];
    logic             carry_d[STAGES];
    logic             carry_q[STAGES];
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] valid_q;
    flags_t            flags_d;
    flags_t            flags_q;

    assign en     = !valid_q[LAST] || bus.out_ready;
    assign accept = bus.in_valid && en;
    assign sub_op = (bus.sub == OP_SUB);

    always_comb begin
        a_src[0]   = bus.a;
        bb_src[0]  = sub_op ? ~bus.b : bus.b;
        cin_src[0] = sub_op;
        s_src[0]   = {WIDTH{1'b0}};
        for (int k = 1; k < STAGES; k++) begin
            a_src[k]   = a_q[k-1];
            bb_src[k]  = bb_q[k-1];
            cin_src[k] = carry_q[k-1];
            s_src[k]   = s_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        add_sub_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a    (a_src[k][k*CHUNK +: CHUNK]),
            .b    (bb_src[k][k*CHUNK +: CHUNK]),
            .cin  (cin_src[k]),
            .s    (chunk_s[k]),
            .cout (chunk_c[k]),
            .cmsb (chunk_m[k])
        );
    end

    // The whole pipe advances together or holds together; bubbles are not collapsed.
    always_comb begin
        valid_d[0] = en ? accept : valid_q[0];
        for (int k = 1; k < STAGES; k++) begin
            valid_d[k] = en ? valid_q[k-1] : valid_q[k];
        end
        for (int k = 0; k < STAGES; k++) begin
            if (en) begin
                a_d[k]                    = a_src[k];
                bb_d[k]                   = bb_src[k];
                s_d[k]                    = s_src[k];
                s_d[k][k*CHUNK +: CHUNK]  = chunk_s[k];
                carry_d[k]                = chunk_c[k];
            end else begin
                a_d[k]     = a_q[k];
                bb_d[k]    = bb_q[k];
                s_d[k]     = s_q[k];
                carry_d[k] = carry_q[k];
            end
        end
    end

    always_comb begin
        if (en) begin
            flags_d.cout = chunk_c[LAST];
            flags_d.ovf  = chunk_m[LAST] ^ chunk_c[LAST];
            flags_d.zero = (s_d[LAST] == {WIDTH{1'b0}});
            flags_d.neg  = s_d[LAST][WIDTH-1];
        end else begin
            flags_d = flags_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= {STAGES{1'b0}};
            flags_q <= flags_t'(4'b0000);
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]     <= {WIDTH{1'b0}};
                bb_q[k]    <= {WIDTH{1'b0}};
                s_q[k]     <= {WIDTH{1'b0}};
                carry_q[k] <= 1'b0;
            end
        end else begin
            valid_q <= valid_d;
            flags_q <= flags_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]     <= a_d[k];
                bb_q[k]    <= bb_d[k];
                s_q[k]     <= s_d[k];
                carry_q[k] <= carry_d[k];
            end
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = valid_q[LAST];
    assign bus.z         = s_q[LAST];
    assign bus.cout      = flags_q.cout;
    assign bus.ovf       = flags_q.ovf;
    assign bus.zero      = flags_q.zero;
    assign bus.neg       = flags_q.neg;

endmodule
